// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Lookup is combinational on pcf; the execute stage trains the tables one branch per cycle.
module branch_target_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcf,
  output logic        hitf,
  output logic        predict_takenf,
  output logic [31:0] pc_predf,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tags    [ENTRIES];
  logic [31:0]         targets [ENTRIES];
  logic [1:0]          ctrs    [ENTRIES];

  logic [INDEX_BITS-1:0] look_idx;
  logic [TAG_BITS-1:0]   look_tag;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  logic                  unused_bits;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    case (c)
      2'b00:   ctr_inc = 2'b01;
      2'b01:   ctr_inc = 2'b10;
      2'b10:   ctr_inc = 2'b11;
      2'b11:   ctr_inc = 2'b11;
      default: ctr_inc = 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    case (c)
      2'b00:   ctr_dec = 2'b00;
      2'b01:   ctr_dec = 2'b00;
      2'b10:   ctr_dec = 2'b01;
      2'b11:   ctr_dec = 2'b10;
      default: ctr_dec = 2'b01;
    endcase
  endfunction

  assign look_idx    = pcf[INDEX_BITS+1:2];
  assign look_tag    = pcf[31:INDEX_BITS+2];
  assign upd_idx     = update_pc[INDEX_BITS+1:2];
  assign upd_tag     = update_pc[31:INDEX_BITS+2];
  assign upd_hit     = valid[upd_idx] && (tags[upd_idx] == upd_tag);
  assign unused_bits = ^update_pc[1:0];

  // Lookup reads pre-update table contents; no write-to-read bypass.
  always_comb begin
    hitf           = 1'b0;
    predict_takenf = 1'b0;
    pc_predf       = pcf + 32'd4;
    if (valid[look_idx] && (tags[look_idx] == look_tag)) begin
      hitf           = 1'b1;
      predict_takenf = ctrs[look_idx][1];
      if (ctrs[look_idx][1]) begin
        pc_predf = targets[look_idx];
      end else begin
        pc_predf = pcf + 32'd4;
      end
    end else begin
      hitf           = 1'b0;
      predict_takenf = 1'b0;
      pc_predf       = pcf + 32'd4;
    end
  end

  // Valid bits and counters: reset wins over a coincident update.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        ctrs[i] <= 2'b01;
      end
    end else if (update_en) begin
      if (upd_hit) begin
        if (update_taken) begin
          ctrs[upd_idx] <= ctr_inc(ctrs[upd_idx]);
        end else begin
          ctrs[upd_idx] <= ctr_dec(ctrs[upd_idx]);
        end
      end else if (update_taken) begin
        valid[upd_idx] <= 1'b1;
        ctrs[upd_idx]  <= 2'b10;
      end
    end
  end

  // Tags and targets carry no reset; a taken update (hit or allocate) rewrites them.
  always_ff @(posedge clk) begin
    if (!reset && update_en && update_taken) begin
      tags[upd_idx]    <= upd_tag;
      targets[upd_idx] <= update_target;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor with hand-computed expectations.
module tb_branch_target_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] pcf;
  logic        hitf;
  logic        predict_takenf;
  logic [31:0] pc_predf;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;

  int tests_run;
  int tests_failed;

  branch_target_predictor dut (
    .clk(clk),
    .reset(reset),
    .pcf(pcf),
    .hitf(hitf),
    .predict_takenf(predict_takenf),
    .pc_predf(pc_predf),
    .update_en(update_en),
    .update_pc(update_pc),
    .update_taken(update_taken),
    .update_target(update_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    update_en     = 1'b1;
    update_pc     = pc;
    update_taken  = taken;
    update_target = tgt;
    step();
    update_en = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_hit,
                      input logic exp_taken, input logic [31:0] exp_pred);
    pcf = pc;
    #1;
    check({tag, ".hit"}, {31'd0, hitf}, {31'd0, exp_hit});
    check({tag, ".taken"}, {31'd0, predict_takenf}, {31'd0, exp_taken});
    check({tag, ".pred"}, pc_predf, exp_pred);
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    pcf           = 32'h0040_0010;
    update_en     = 1'b0;
    update_pc     = 32'd0;
    update_taken  = 1'b0;
    update_target = 32'd0;
    step();
    step();
    look("reset", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    reset = 1'b0;
    step();
    look("post_reset", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);

    // Allocation lands in WT
    train(32'h0040_0010, 1'b1, 32'h0040_0040);
    look("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);

    for (int i = 0; i < 3; i++) train(32'h0040_0010, 1'b1, 32'h0040_0040);
    look("sat_st", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
    train(32'h0040_0010, 1'b0, 32'h0040_0040);
    look("st_to_wt", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
    train(32'h0040_0010, 1'b0, 32'h0040_0040);
    look("wt_to_wnt", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    for (int i = 0; i < 3; i++) train(32'h0040_0010, 1'b0, 32'h0040_0040);
    look("sat_snt", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    train(32'h0040_0010, 1'b1, 32'h0040_0040);
    look("snt_to_wnt", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    train(32'h0040_0010, 1'b1, 32'h0040_0040);
    look("wnt_to_wt", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);

    train(32'h0040_0020, 1'b0, 32'h0040_0080);
    look("miss_nt", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);

    // 0x00400110 aliases index 4 with a different tag
    train(32'h0040_0110, 1'b1, 32'h0040_0200);
    look("alias_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    look("alias_new", 32'h0040_0110, 1'b1, 1'b1, 32'h0040_0200);

    // Not-taken hit must keep the stored target
    train(32'h0040_0110, 1'b1, 32'h0040_0200);
    train(32'h0040_0110, 1'b0, 32'h1234_5678);
    look("nt_keeps_tgt", 32'h0040_0110, 1'b1, 1'b1, 32'h0040_0200);
    train(32'h0040_0110, 1'b0, 32'h1234_5678);
    look("nt_to_wnt", 32'h0040_0110, 1'b1, 1'b0, 32'h0040_0114);

    // Same-cycle lookup and update: no bypass
    pcf           = 32'h0040_0030;
    update_en     = 1'b1;
    update_pc     = 32'h0040_0030;
    update_taken  = 1'b1;
    update_target = 32'h0040_0500;
    look("same_cyc", 32'h0040_0030, 1'b0, 1'b0, 32'h0040_0034);
    step();
    update_en = 1'b0;
    look("same_next", 32'h0040_0030, 1'b1, 1'b1, 32'h0040_0500);

    // Top-of-address-space wrap and training there
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);
    train(32'hFFFF_FFFC, 1'b1, 32'h0000_0100);
    look("wrap_hit", 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0100);

    // Reset coincident with an update: reset wins and clears everything
    reset         = 1'b1;
    update_en     = 1'b1;
    update_pc     = 32'h0040_0040;
    update_taken  = 1'b1;
    update_target = 32'h0040_0600;
    step();
    reset     = 1'b0;
    update_en = 1'b0;
    look("rst_upd", 32'h0040_0040, 1'b0, 1'b0, 32'h0040_0044);
    look("rst_clear", 32'h0040_0030, 1'b0, 1'b0, 32'h0040_0034);
    look("rst_clear_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    // Counter restarts at WT after reset-time re-allocation
    train(32'h0040_0040, 1'b1, 32'h0040_0600);
    train(32'h0040_0040, 1'b0, 32'h0040_0600);
    look("realloc_wnt", 32'h0040_0040, 1'b1, 1'b0, 32'h0040_0044);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
